io_handshake_seq: RTL and testbench

//  Sequences the processor's external 4-phase handshake (hs_out/hs_in) for IN and OUT instructions.

---
 rtl/io_handshake_seq_pkg.sv | 23 ++
 rtl/io_handshake_seq_sync_2ff.sv | 22 ++
 rtl/io_handshake_seq.sv | 149 ++++++++++++++
 tb/tb_io_handshake_seq.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_handshake_seq_pkg.sv
// Shared definitions for the IN/OUT 4-phase handshake sequencer.
// Holds the state encoding, default widths and a wait-state helper.
package io_handshake_seq_pkg;

  localparam int D_WIDTH_DEF  = 8;
  localparam int TO_WIDTH_DEF = 8;
  localparam int TO_LIMIT_DEF = 200;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_O_SETUP    = 3'd1,
    ST_O_WAIT_ACK = 3'd2,
    ST_O_WAIT_REL = 3'd3,
    ST_I_WAIT_ACK = 3'd4,
    ST_I_WAIT_REL = 3'd5
  } state_t;

  function automatic logic is_wait(input state_t s);
    return (s == ST_O_WAIT_ACK) || (s == ST_O_WAIT_REL) ||
           (s == ST_I_WAIT_ACK) || (s == ST_I_WAIT_REL);
  endfunction

endpackage

// File: rtl/io_handshake_seq_sync_2ff.sv
// Two-flop synchroniser for the asynchronous peer acknowledge.
// Cleared by the same synchronous reset as the sequencer.
module sync_2ff (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (clr) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/io_handshake_seq.sv
// Sequences the 4-phase hs_out/hs_in handshake for IN and OUT instructions,
// owns bus_out and the RIN load strobe, and stalls the pipeline meanwhile.
module io_handshake_seq
  import io_handshake_seq_pkg::*;
#(
  parameter int D_WIDTH  = D_WIDTH_DEF,
  parameter int TO_WIDTH = TO_WIDTH_DEF,
  parameter int TO_LIMIT = TO_LIMIT_DEF
) (
  input  logic               g_clk,
  input  logic               g_clr,
  input  logic               out_req,
  input  logic               in_req,
  input  logic [D_WIDTH-1:0] out_data,
  input  logic [D_WIDTH-1:0] bus_in,
  input  logic               hs_in,
  input  logic               clr_to,
  output logic               hs_out,
  output logic [D_WIDTH-1:0] bus_out,
  output logic [D_WIDTH-1:0] rin_data,
  output logic               rin_load,
  output logic               stall,
  output logic               done,
  output logic               timeout,
  output state_t             fsm_state
);

  // Handshake: a request raised on hs_out is held until the synchronised
  // hs_in rises, then hs_out drops and the transfer ends when hs_in falls.
  state_t state, state_nxt;
  logic hs_s;
  logic [TO_WIDTH-1:0] cnt;
  logic hs_out_nxt, rin_load_nxt, done_nxt, to_set;
  logic [D_WIDTH-1:0] bus_out_nxt, rin_data_nxt;
  logic in_wait, to_hit, start_ok;

  sync_2ff u_sync (
    .clk (g_clk),
    .clr (g_clr),
    .d   (hs_in),
    .q   (hs_s)
  );

  assign in_wait   = is_wait(state);
  assign to_hit    = in_wait && (cnt == TO_WIDTH'(TO_LIMIT - 1));
  assign start_ok  = (state == ST_IDLE) && !hs_s && !done;
  assign stall     = (state != ST_IDLE) || ((out_req || in_req) && !done);
  assign fsm_state = state;

  always_ff @(posedge g_clk) begin
    if (g_clr) begin
      state    <= ST_IDLE;
      hs_out   <= 1'b0;
      bus_out  <= '0;
      rin_data <= '0;
      rin_load <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      hs_out   <= hs_out_nxt;
      bus_out  <= bus_out_nxt;
      rin_data <= rin_data_nxt;
      rin_load <= rin_load_nxt;
      done     <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start_ok && out_req)     state_nxt = ST_O_SETUP;
        else if (start_ok && in_req) state_nxt = ST_I_WAIT_ACK;
      end
      ST_O_SETUP:    state_nxt = ST_O_WAIT_ACK;
      ST_O_WAIT_ACK: begin
        if (hs_s)        state_nxt = ST_O_WAIT_REL;
        else if (to_hit) state_nxt = ST_IDLE;
      end
      ST_I_WAIT_ACK: begin
        if (hs_s)        state_nxt = ST_I_WAIT_REL;
        else if (to_hit) state_nxt = ST_IDLE;
      end
      ST_O_WAIT_REL, ST_I_WAIT_REL: begin
        if (!hs_s || to_hit) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    hs_out_nxt   = hs_out;
    bus_out_nxt  = bus_out;
    rin_data_nxt = rin_data;
    rin_load_nxt = 1'b0;
    done_nxt     = 1'b0;
    to_set       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_ok && out_req)     bus_out_nxt = out_data;
        else if (start_ok && in_req) hs_out_nxt  = 1'b1;
      end
      ST_O_SETUP: hs_out_nxt = 1'b1;
      ST_O_WAIT_ACK: begin
        if (hs_s) begin
          hs_out_nxt = 1'b0;
        end else if (to_hit) begin
          hs_out_nxt = 1'b0;
          done_nxt   = 1'b1;
          to_set     = 1'b1;
        end
      end
      ST_I_WAIT_ACK: begin
        if (hs_s) begin
          hs_out_nxt   = 1'b0;
          rin_data_nxt = bus_in;
          rin_load_nxt = 1'b1;
        end else if (to_hit) begin
          hs_out_nxt = 1'b0;
          done_nxt   = 1'b1;
          to_set     = 1'b1;
        end
      end
      ST_O_WAIT_REL, ST_I_WAIT_REL: begin
        if (!hs_s) begin
          done_nxt = 1'b1;
        end else if (to_hit) begin
          done_nxt = 1'b1;
          to_set   = 1'b1;
        end
      end
      default: hs_out_nxt = 1'b0;
    endcase
  end

  // Counter restarts on every state change and saturates instead of wrapping.
  always_ff @(posedge g_clk) begin
    if (g_clr) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      if (state_nxt != state)      cnt <= '0;
      else if (in_wait && cnt != '1) cnt <= cnt + 1'b1;
      if (to_set)      timeout <= 1'b1;
      else if (clr_to) timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_io_handshake_seq.sv
// Bench for io_handshake_seq: behavioural peer, transfer scoreboard,
// table-driven transfers and hand-written timing/corner sequences.
module tb_io_handshake_seq;
  import io_handshake_seq_pkg::*;

  localparam int DW  = 8;
  localparam int TOL = 16;
  localparam int RW  = DW + 2;

  logic g_clk = 1'b0;
  logic g_clr = 1'b1;
  logic out_req = 1'b0, in_req = 1'b0, clr_to = 1'b0, hs_in = 1'b0;
  logic [DW-1:0] out_data = '0, bus_in = '0;
  logic hs_out, rin_load, stall, done, timeout;
  logic [DW-1:0] bus_out, rin_data;
  state_t fsm_state;

  io_handshake_seq #(.D_WIDTH(DW), .TO_WIDTH(8), .TO_LIMIT(TOL)) dut (
    .g_clk(g_clk), .g_clr(g_clr), .out_req(out_req), .in_req(in_req),
    .out_data(out_data), .bus_in(bus_in), .hs_in(hs_in), .clr_to(clr_to),
    .hs_out(hs_out), .bus_out(bus_out), .rin_data(rin_data),
    .rin_load(rin_load), .stall(stall), .done(done), .timeout(timeout),
    .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  always #5 g_clk = ~g_clk;

  int n_vec = 0, n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge g_clk);
  endtask

  // ---------------- peer model (sole driver of hs_in) ----------------
  bit peer_silent = 0, peer_hold = 0;
  int ack_dly = 1, rel_dly = 1;
  int pst = 0, pcnt = 0;

  always @(negedge g_clk) begin
    if (peer_hold) begin
      hs_in = 1'b1;
      pst   = 0;
    end else if (g_clr) begin
      hs_in = 1'b0;
      pst   = 0;
    end else begin
      case (pst)
        0: begin
          hs_in = 1'b0;
          if (hs_out && !peer_silent) begin pcnt = ack_dly; pst = 1; end
        end
        1: if (pcnt <= 1) begin hs_in = 1'b1; pst = 2; end else pcnt--;
        2: if (!hs_out) begin pcnt = rel_dly; pst = 3; end
        3: if (pcnt <= 1) begin hs_in = 1'b0; pst = 0; end else pcnt--;
        default: pst = 0;
      endcase
    end
  end

  // ---------------- scoreboard: {in_transfer, timeout, data} per done ----------------
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] got_w, exp_w;
  bit rin_seen = 0;
  int done_cnt = 0, rin_cnt = 0;

  always @(negedge g_clk) begin
    if (g_clr) rin_seen = 0;
    if (rin_load) begin rin_seen = 1; rin_cnt++; end
    if (done) begin
      done_cnt++;
      got_w = {rin_seen, timeout, rin_seen ? rin_data : bus_out};
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL sb_unexpected_done: got %0h want none", got_w);
      end else begin
        exp_w = exp_q.pop_front();
        check("sb_transfer", 32'(got_w), 32'(exp_w));
      end
      rin_seen = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_xfer(input string name, input bit is_in, input logic [DW-1:0] d);
    bit ok;
    ok = 0;
    if (is_in) begin bus_in = d; in_req = 1'b1; end
    else begin out_data = d; out_req = 1'b1; end
    exp_q.push_back({is_in, 1'b0, d});
    for (int i = 0; i < 400; i++) begin
      tick();
      if (done) begin ok = 1; check({name, "_stall_done"}, 32'(stall), 32'd0); break; end
    end
    if (!ok) begin n_vec++; n_err++; $display("FAIL %s_no_done: got none want done", name); end
    out_req = 1'b0;
    in_req  = 1'b0;
    tick();
  endtask

  typedef struct {
    bit            is_in;
    logic [DW-1:0] data;
    logic [DW-1:0] exp_bus_out;
    logic [DW-1:0] exp_rin_data;
  } vec_t;

  vec_t vecs[6];

  int t_bus, t_hs, t_fall, t_done, t_rl, d0, r0, hs_high, nd;
  bit bad, ok;

  initial begin
    vecs[0] = '{0, 8'h5A, 8'h5A, 8'h00};
    vecs[1] = '{1, 8'h96, 8'h5A, 8'h96};
    vecs[2] = '{0, 8'hFF, 8'hFF, 8'h96};
    vecs[3] = '{1, 8'h81, 8'hFF, 8'h81};
    vecs[4] = '{0, 8'h00, 8'h00, 8'h81};
    vecs[5] = '{1, 8'h7E, 8'h00, 8'h7E};

    // reset state
    repeat (3) tick();
    check("rst_hs_out", 32'(hs_out), 0);
    check("rst_bus_out", 32'(bus_out), 0);
    check("rst_rin_data", 32'(rin_data), 0);
    check("rst_done", 32'(done), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_stall", 32'(stall), 0);
    check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
    g_clr = 1'b0;
    tick();

    // table-driven transfers with random peer latencies
    for (int v = 0; v < 6; v++) begin
      ack_dly = $urandom_range(1, 6);
      rel_dly = $urandom_range(1, 6);
      run_xfer("tbl", vecs[v].is_in, vecs[v].data);
      check("tbl_bus_out", 32'(bus_out), 32'(vecs[v].exp_bus_out));
      check("tbl_rin_data", 32'(rin_data), 32'(vecs[v].exp_rin_data));
    end
    repeat (3) tick();

    // OUT A5: ack 3 cycles after hs_out, release 2 cycles after hs_out falls.
    // Edge timing: hs_in rises at index 5, two synchroniser edges plus the
    // FSM edge put the hs_out fall at index 8; release gives done at 13.
    ack_dly = 3; rel_dly = 2;
    t_bus = -1; t_hs = -1; t_fall = -1; t_done = -1; d0 = done_cnt;
    out_data = 8'hA5; out_req = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 8'hA5});
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (t_bus < 0 && bus_out == 8'hA5) t_bus = i;
      if (t_hs < 0 && hs_out) t_hs = i;
      if (t_fall < 0 && t_hs > 0 && !hs_out) t_fall = i;
      if (t_done < 0 && done) begin
        t_done = i;
        check("a_stall_done", 32'(stall), 0);
        out_req = 1'b0;
      end
    end
    check("a_t_bus_out", 32'(t_bus), 1);
    check("a_t_hs_rise", 32'(t_hs), 2);
    check("a_t_hs_fall", 32'(t_fall), 8);
    check("a_t_done", 32'(t_done), 13);
    check("a_done_pulses", 32'(done_cnt - d0), 1);

    // IN 3C: rin_load on the same edge hs_out falls.
    ack_dly = 1; rel_dly = 1;
    t_rl = -1; t_done = -1; d0 = done_cnt; r0 = rin_cnt;
    bus_in = 8'h3C; in_req = 1'b1;
    exp_q.push_back({1'b1, 1'b0, 8'h3C});
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (t_rl < 0 && rin_load) begin
        t_rl = i;
        check("b_hs_out_at_load", 32'(hs_out), 0);
        check("b_rin_data", 32'(rin_data), 32'h3C);
      end
      if (t_done < 0 && done) begin t_done = i; in_req = 1'b0; end
    end
    check("b_t_rin_load", 32'(t_rl), 5);
    check("b_t_done", 32'(t_done), 9);
    check("b_rin_pulses", 32'(rin_cnt - r0), 1);
    check("b_done_pulses", 32'(done_cnt - d0), 1);

    // both requests: OUT first, then IN
    ack_dly = 2; rel_dly = 2;
    d0 = done_cnt; r0 = rin_cnt; nd = 0;
    out_data = 8'h11; bus_in = 8'h22; out_req = 1'b1; in_req = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 8'h11});
    exp_q.push_back({1'b1, 1'b0, 8'h22});
    for (int i = 0; i < 200 && nd < 2; i++) begin
      tick();
      if (done) begin
        nd++;
        if (nd == 1) begin
          check("c_first_is_out", 32'(rin_cnt - r0), 0);
          check("c_bus_out", 32'(bus_out), 32'h11);
          out_req = 1'b0;
        end else begin
          check("c_rin_data", 32'(rin_data), 32'h22);
          in_req = 1'b0;
        end
      end
    end
    check("c_two_done", 32'(nd), 2);
    out_req = 1'b0; in_req = 1'b0;
    repeat (3) tick();

    // silent peer: hs_out high for exactly TOL cycles, then abort
    peer_silent = 1; hs_high = 0; d0 = done_cnt; t_done = -1;
    out_data = 8'h5A; out_req = 1'b1;
    exp_q.push_back({1'b0, 1'b1, 8'h5A});
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (hs_out) hs_high++;
      if (t_done < 0 && done) begin
        t_done = i;
        check("d_timeout_set", 32'(timeout), 1);
        out_req = 1'b0;
      end
    end
    check("d_hs_high_cycles", 32'(hs_high), TOL);
    check("d_done_pulses", 32'(done_cnt - d0), 1);
    check("d_timeout_sticky", 32'(timeout), 1);
    clr_to = 1'b1; tick(); clr_to = 1'b0; tick();
    check("d_timeout_clr", 32'(timeout), 0);

    // reset mid-transfer in O_WAIT_ACK
    d0 = done_cnt; ok = 0;
    out_data = 8'h77; out_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (fsm_state == ST_O_WAIT_ACK) begin ok = 1; break; end
    end
    check("e_reached_wait_ack", 32'(ok), 1);
    check("e_hs_out_before", 32'(hs_out), 1);
    out_req = 1'b0; g_clr = 1'b1;
    tick();
    check("e_hs_out", 32'(hs_out), 0);
    check("e_bus_out", 32'(bus_out), 0);
    check("e_stall", 32'(stall), 0);
    check("e_state", 32'(fsm_state), 32'(ST_IDLE));
    g_clr = 1'b0; peer_silent = 0;
    repeat (5) tick();
    check("e_no_done", 32'(done_cnt - d0), 0);

    // peer not released: no start until hs_in falls
    peer_hold = 1;
    repeat (4) tick();
    bad = 0; d0 = done_cnt;
    out_data = 8'hC3; out_req = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 8'hC3});
    for (int i = 0; i < 10; i++) begin
      tick();
      if (hs_out !== 1'b0 || stall !== 1'b1 || fsm_state != ST_IDLE) bad = 1;
    end
    check("f_hold_idle_stalled", 32'(bad), 0);
    check("f_hold_no_done", 32'(done_cnt - d0), 0);
    peer_hold = 0;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (done) begin ok = 1; out_req = 1'b0; break; end
    end
    check("f_done_after_release", 32'(ok), 1);
    check("f_bus_out", 32'(bus_out), 32'hC3);
    out_req = 1'b0;
    repeat (4) tick();

    check("sb_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
